fifo_read_ctrl: RTL and testbench
=================================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 Parameter Width, default 4, data word width in bits, SHALL be supported.
REQ-002 Parameter Address, default 2, memory address width in bits; depth = 2**Address, SHALL be supported.
REQ-003 r_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 r_rst  input  1  reset, synchronous, active-low.
REQ-005 wptr_sync  input  Address+1  Gray-coded write pointer, already two-flop synchronized into r_clk.
REQ-006 mem_rdata  input  Width  registered read data from the memory, valid one r_clk after r_en.
REQ-007 dout_ready  input  1  consumer accepts dout this cycle.
REQ-008 r_en  output  1  memory read enable, combinational.
REQ-009 r_addr  output  Address  binary read address to memory.
REQ-010 rptr_gray  output  Address+1  registered Gray read pointer, exported for synchronization into the write domain.
REQ-011 empty  output  1  registered empty flag.
REQ-012 dout  output  Width  read data to consumer.
REQ-013 dout_valid  output  1  dout holds an unconsumed word.
REQ-014 level  output  Address+1  words in FIFO not yet fetched, as seen by the read side.

Function
REQ-015 rbin (Address+1 bits, binary) SHALL increment by 1 on every cycle with r_en=1, wrapping from 2**(Address+1)-1 to 0.
REQ-016 r_addr SHALL equal rbin[Address-1:0]; rptr_gray SHALL equal the registered value (rbin>>1)^rbin.
REQ-017 empty SHALL be registered as (Gray of rbin_next == wptr_sync), where rbin_next is rbin plus r_en.
REQ-018 r_en SHALL equal !empty && (!dout_valid || dout_ready); a read SHALL never be issued while empty=1.
REQ-019 dout SHALL pass mem_rdata through directly; its value is don't-care while dout_valid=0.
REQ-020 dout_valid SHALL be set at the edge after a cycle with r_en=1, cleared at the edge after a cycle with dout_valid && dout_ready && !r_en, and held otherwise.
REQ-021 The consumer-side handshake SHALL support one word per cycle sustained (show-ahead), with first-word latency of 1 cycle from empty deasserting to dout_valid=1.
REQ-022 dout and dout_valid SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-023 level SHALL be registered as (gray2bin(wptr_sync) - rbin_next) modulo 2**(Address+1), and SHALL never exceed 2**Address.
REQ-024 On simultaneous wptr_sync advance and read, empty and level SHALL reflect both events in the same cycle.
REQ-025 Pointer wrap-around SHALL change exactly one bit of rptr_gray.

Reset
REQ-026 While r_rst=0 at a rising r_clk edge: rbin=0, rptr_gray=0, r_addr=0, empty=1, dout_valid=0, level=0; r_en SHALL therefore be 0 in the following cycle.
REQ-027 Reset asserted mid-stream SHALL discard any pending or presented word: dout_valid=0 at the next edge, with no handshake completing.

Structure
REQ-028 Constants DEPTH=2**Address and PTR_W=Address+1 SHALL live in the shared FIFO package used by both the write and read controllers.
REQ-029 A single sub-module gray2bin (parameter N) SHALL perform Gray-to-binary conversion; it SHALL be shared with the write-side controller.
REQ-030 The block SHALL instantiate no memory; it connects to the existing dual-port memory through r_en, r_addr and mem_rdata.

Verification (Width=4, Address=2)
REQ-031 Reset, then wptr_sync=0 held -> empty=1, r_en=0, dout_valid=0, level=0 for 10 cycles.
REQ-032 wptr_sync stepped 0->1 (Gray), dout_ready=1 -> empty falls, r_en=1 for one cycle with r_addr=0, dout_valid=1 for exactly one cycle with dout=mem[0], then empty=1.
REQ-033 Four words written (wptr_sync=Gray 4=6), dout_ready=0 -> one prefetch only, dout_valid=1, level=3, dout stable for 5 cycles; then ready=1 -> four words in consecutive cycles, addresses 0,1,2,3.
REQ-034 Stream 12 words across two pointer wraps with dout_ready toggling 1,0 -> order preserved, rptr_gray sequence 0,1,3,2,6,7,5,4,0 with single-bit changes.
REQ-035 r_rst=0 pulsed while dout_valid=1 and level=2 -> dout_valid=0, empty=1, rptr_gray=0 at the next edge; no extra read issued.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and pointer-width helpers for the async FIFO read and write controllers.
package fifo_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int ADDR_DEF  = 2;
  localparam int DEPTH     = 2 ** ADDR_DEF;
  localparam int PTR_W     = ADDR_DEF + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary pointer conversion, shared by both FIFO pointer domains.
module gray2bin #(
  parameter int N = 3
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: Gray read pointer, empty/level flags
// and a show-ahead output stage fed by the dual-port memory's registered read port.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int Width   = WIDTH_DEF,
  parameter int Address = ADDR_DEF
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [Address:0]     wptr_sync,
  input  logic [Width-1:0]     mem_rdata,
  input  logic                 dout_ready,
  output logic                 r_en,
  output logic [Address-1:0]   r_addr,
  output logic [Address:0]     rptr_gray,
  output logic                 empty,
  output logic [Width-1:0]     dout,
  output logic                 dout_valid,
  output logic [Address:0]     level
);

  localparam int PtrW = ptr_w_of(Address);

  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] rbin_next;
  logic [PtrW-1:0] rgray_next;
  logic [PtrW-1:0] wbin_sync;

  gray2bin #(.N(PtrW)) u_wptr_g2b (
    .gray (wptr_sync),
    .bin  (wbin_sync)
  );

  // A fetch is issued only when the output stage is free or being drained this cycle.
  assign r_en       = !empty && (!dout_valid || dout_ready);
  assign rbin_next  = rbin + PtrW'(r_en);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign r_addr     = rbin[Address-1:0];
  assign dout       = mem_rdata;

  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      rbin       <= '0;
      rptr_gray  <= '0;
      empty      <= 1'b1;
      level      <= '0;
      dout_valid <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      // Compared against the post-read pointer so a same-cycle write and read both count.
      empty     <= (rgray_next == wptr_sync);
      level     <= wbin_sync - rbin_next;
      if (r_en)
        dout_valid <= 1'b1;
      else if (dout_ready)
        dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: the bench plays the write side and the memory.
module tb_fifo_read_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic [2:0] wptr_sync;
  logic [3:0] mem_rdata;
  logic       dout_ready;
  logic       r_en;
  logic [1:0] r_addr;
  logic [2:0] rptr_gray;
  logic       empty;
  logic [3:0] dout;
  logic       dout_valid;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [4];
  logic [2:0] gseq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) if (r_en) mem_rdata <= mem[r_addr];

  fifo_read_ctrl #(.Width(4), .Address(2)) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .wptr_sync  (wptr_sync),
    .mem_rdata  (mem_rdata),
    .dout_ready (dout_ready),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .rptr_gray  (rptr_gray),
    .empty      (empty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .level      (level)
  );

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    r_rst = 1'b0;
    wptr_sync = 3'd0;
    dout_ready = 1'b0;
    tick();
    r_rst = 1'b1;
  endtask

  task automatic test_reset();
    r_rst = 1'b0;
    wptr_sync = 3'd0;
    dout_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (empty !== 1'b1 || dout_valid !== 1'b0 || level !== 3'd0 || rptr_gray !== 3'd0 ||
        r_addr !== 2'd0 || r_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: empty=%b valid=%b level=%0d gray=%0d addr=%0d r_en=%b, need 1 0 0 0 0 0",
               empty, dout_valid, level, rptr_gray, r_addr, r_en);
    end
    r_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (empty !== 1'b1 || r_en !== 1'b0 || dout_valid !== 1'b0 || level !== 3'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: empty=%b r_en=%b valid=%b level=%0d, need 1 0 0 0",
                 i, empty, r_en, dout_valid, level);
      end
    end
  endtask

  task automatic test_single_word();
    mem[0] = 4'hA;
    dout_ready = 1'b1;
    wptr_sync = 3'b001;
    tick();
    checks++;
    if (empty !== 1'b0 || r_en !== 1'b1 || r_addr !== 2'd0 || level !== 3'd1) begin
      errors++;
      $display("FAIL single_fetch: empty=%b r_en=%b addr=%0d level=%0d, need 0 1 0 1",
               empty, r_en, r_addr, level);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 4'hA || empty !== 1'b1 || r_en !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL single_present: valid=%b dout=%h empty=%b r_en=%b level=%0d, need 1 a 1 0 0",
               dout_valid, dout, empty, r_en, level);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || empty !== 1'b1 || rptr_gray !== 3'd1) begin
      errors++;
      $display("FAIL single_drain: valid=%b empty=%b gray=%0d, need 0 1 1",
               dout_valid, empty, rptr_gray);
    end
  endtask

  task automatic test_prefetch_hold();
    logic [3:0] exp_d [4];
    exp_d = '{4'h3, 4'h5, 4'h9, 4'hC};
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = exp_d[i];
    wptr_sync = 3'b110;
    tick();
    checks++;
    if (empty !== 1'b0 || r_en !== 1'b1 || r_addr !== 2'd0 || level !== 3'd4) begin
      errors++;
      $display("FAIL prefetch_issue: empty=%b r_en=%b addr=%0d level=%0d, need 0 1 0 4",
               empty, r_en, r_addr, level);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== 4'h3 || level !== 3'd3 || r_en !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b dout=%h level=%0d r_en=%b, need 1 3 3 0",
                 i, dout_valid, dout, level, r_en);
      end
    end
    dout_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_d[k] || level !== 3'(3 - k) ||
          r_en !== (k < 3) || (k < 3 && r_addr !== 2'(k + 1))) begin
        errors++;
        $display("FAIL burst_word%0d: valid=%b dout=%h level=%0d r_en=%b addr=%0d, need 1 %h %0d %0d %0d",
                 k, dout_valid, dout, level, r_en, r_addr, exp_d[k], 3 - k, (k < 3), (k + 1) % 4);
      end
      tick();
    end
    checks++;
    if (dout_valid !== 1'b0 || empty !== 1'b1 || rptr_gray !== 3'd6) begin
      errors++;
      $display("FAIL burst_end: valid=%b empty=%b gray=%0d, need 0 1 6", dout_valid, empty, rptr_gray);
    end
  endtask

  task automatic test_stream_wrap();
    int wbin = 0;
    int consumed = 0;
    int gidx = 0;
    int cyc = 0;
    logic [2:0] prev = 3'd0;
    logic ready_t = 1'b1;
    logic [3:0] exp_w;
    do_reset();
    while (consumed < 12 && cyc < 300) begin
      tick();
      cyc++;
      if (rptr_gray !== prev) begin
        gidx++;
        checks++;
        if (rptr_gray !== gseq[gidx % 8] || $countones(rptr_gray ^ prev) != 1) begin
          errors++;
          $display("FAIL gray_step%0d: got %0d after %0d, need %0d", gidx, rptr_gray, prev, gseq[gidx % 8]);
        end
        prev = rptr_gray;
      end
      if (wbin < 12 && wbin - consumed < 4) begin
        mem[wbin % 4] = 4'((wbin * 7 + 3) % 16);
        wbin++;
        wptr_sync = gseq[wbin % 8];
      end
      dout_ready = ready_t;
      ready_t = !ready_t;
      #1;
      if (dout_valid && dout_ready) begin
        exp_w = 4'((consumed * 7 + 3) % 16);
        checks++;
        if (dout !== exp_w) begin
          errors++;
          $display("FAIL stream_word%0d: dout=%h, need %h", consumed, dout, exp_w);
        end
        consumed++;
      end
    end
    checks++;
    if (consumed != 12 || gidx != 12 || rptr_gray !== 3'd6) begin
      errors++;
      $display("FAIL stream_done: words=%0d gray_steps=%0d gray=%0d cycles=%0d, need 12 12 6",
               consumed, gidx, rptr_gray, cyc);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mem[0] = 4'h1;
    mem[1] = 4'h2;
    mem[2] = 4'h4;
    wptr_sync = 3'b010;
    tick();
    tick();
    checks++;
    if (dout_valid !== 1'b1 || level !== 3'd2 || dout !== 4'h1) begin
      errors++;
      $display("FAIL midreset_setup: valid=%b level=%0d dout=%h, need 1 2 1", dout_valid, level, dout);
    end
    r_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b0 || empty !== 1'b1 || rptr_gray !== 3'd0 || level !== 3'd0 ||
          r_en !== 1'b0 || r_addr !== 2'd0) begin
        errors++;
        $display("FAIL midreset_cycle%0d: valid=%b empty=%b gray=%0d level=%0d r_en=%b addr=%0d, need 0 1 0 0 0 0",
                 i, dout_valid, empty, rptr_gray, level, r_en, r_addr);
      end
    end
    wptr_sync = 3'd0;
    r_rst = 1'b1;
    tick();
  endtask

  initial begin
    r_rst = 1'b0;
    wptr_sync = 3'd0;
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 4'h0;
    test_reset();
    test_single_word();
    test_prefetch_hold();
    test_stream_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
